// File: rtl/ysyx_23060136_ifu_idu_skid_reg.sv
// Fetch-to-decode two-entry skid register (main drives decode, skid absorbs one beat of back-pressure).
// Define YSYX_23060136_IFID_PERF_EN to add the stall/bubble performance counters.
module ysyx_23060136_ifu_idu_skid_reg #(
    parameter int                BITS_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IFU_o_valid,
    input  logic [BITS_W-1:0] IFU_o_pc,
    input  logic [INST_W-1:0] IFU_o_inst,
    input  logic              IFU_o_commit,
    output logic              IFU_i_ready,
    output logic              IDU_i_valid,
    output logic [BITS_W-1:0] IDU_i_pc,
    output logic [INST_W-1:0] IDU_i_inst,
    output logic              IDU_i_commit,
    input  logic              IDU_o_ready,
    input  logic              EXU_o_flush
`ifdef YSYX_23060136_IFID_PERF_EN
    ,
    output logic [63:0]       perf_stall_cnt,
    output logic [63:0]       perf_bubble_cnt
`endif
);

    // State bits are {skid_v, main_v}.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [BITS_W-1:0]   r_main_pc;
    logic [INST_W-1:0]   r_main_inst;
    logic                r_main_commit;
    logic [BITS_W-1:0]   r_skid_pc;
    logic [INST_W-1:0]   r_skid_inst;
    logic                r_skid_commit;

    logic w_push;
    logic w_pop;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;
    logic w_drain;

    assign w_push = IFU_o_valid & ~r_state[1];
    assign w_pop  = r_state[0] & IDU_o_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_push) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_push & ~w_pop)      w_state_nxt = S_FULL;
                else if (~w_push & w_pop) w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_pop) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
        if (EXU_o_flush) w_state_nxt = S_EMPTY;
    end

    always_comb begin
        IDU_i_valid  = r_state[0];
        IFU_i_ready  = ~r_state[1];
        IDU_i_pc     = r_main_pc;
        IDU_i_inst   = r_main_inst;
        IDU_i_commit = r_main_commit;
    end

    // Main takes fetch data when it is (or is becoming) the free slot; skid only when main stays occupied.
    assign w_ld_main_in   = w_push & (~r_state[0] | w_pop);
    assign w_ld_main_skid = (r_state == S_FULL) & w_pop;
    assign w_ld_skid      = w_push & r_state[0] & ~w_pop;
    assign w_drain        = (r_state == S_ONE) & w_pop & ~w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_pc     <= '0;
            r_main_inst   <= NOP_INST;
            r_main_commit <= 1'b0;
            r_skid_pc     <= '0;
            r_skid_inst   <= NOP_INST;
            r_skid_commit <= 1'b0;
        end else if (EXU_o_flush) begin
            // pc keeps its last value so decode sees a stable address while empty
            r_main_inst   <= NOP_INST;
            r_main_commit <= 1'b0;
        end else begin
            if (w_ld_main_in) begin
                r_main_pc     <= IFU_o_pc;
                r_main_inst   <= IFU_o_inst;
                r_main_commit <= IFU_o_commit;
            end else if (w_ld_main_skid) begin
                r_main_pc     <= r_skid_pc;
                r_main_inst   <= r_skid_inst;
                r_main_commit <= r_skid_commit;
            end else if (w_drain) begin
                r_main_inst   <= NOP_INST;
                r_main_commit <= 1'b0;
            end
            if (w_ld_skid) begin
                r_skid_pc     <= IFU_o_pc;
                r_skid_inst   <= IFU_o_inst;
                r_skid_commit <= IFU_o_commit;
            end
        end
    end

`ifdef YSYX_23060136_IFID_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            perf_stall_cnt  <= perf_stall_cnt + 64'(r_state[0] & ~IDU_o_ready);
            perf_bubble_cnt <= perf_bubble_cnt + 64'(~r_state[0]);
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060136_ifu_idu_skid_reg.sv
// Randomized + directed bench for the fetch/decode skid register against a queue-based model.
// Define YSYX_23060136_IFID_PERF_EN to also check the performance counters.
module tb_ysyx_23060136_ifu_idu_skid_reg;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_v, ifu_c, ifu_rdy;
    logic [63:0] ifu_pc;
    logic [31:0] ifu_inst;
    logic        idu_v, idu_c, idu_rdy, flush;
    logic [63:0] idu_pc;
    logic [31:0] idu_inst;
`ifdef YSYX_23060136_IFID_PERF_EN
    logic [63:0] perf_stall, perf_bubble;
    logic [63:0] m_stall, m_bubble;
`endif

    always #5 clk = ~clk;

    ysyx_23060136_ifu_idu_skid_reg dut (
        .clk(clk), .rst(rst),
        .IFU_o_valid(ifu_v), .IFU_o_pc(ifu_pc), .IFU_o_inst(ifu_inst), .IFU_o_commit(ifu_c),
        .IFU_i_ready(ifu_rdy),
        .IDU_i_valid(idu_v), .IDU_i_pc(idu_pc), .IDU_i_inst(idu_inst), .IDU_i_commit(idu_c),
        .IDU_o_ready(idu_rdy), .EXU_o_flush(flush)
`ifdef YSYX_23060136_IFID_PERF_EN
        , .perf_stall_cnt(perf_stall), .perf_bubble_cnt(perf_bubble)
`endif
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        c;
    } ent_t;

    // Model: a FIFO of at most two entries plus the pc decode last saw.
    ent_t        q[$];
    logic [63:0] shown_pc;
    int          n_chk = 0;
    int          n_bad = 0;
    bit          last_push;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid",  64'(idu_v),   64'(q.size() != 0));
        chk("ready",  64'(ifu_rdy), 64'(q.size() < 2));
        chk("pc",     idu_pc,       shown_pc);
        chk("inst",   64'(idu_inst), (q.size() != 0) ? 64'(q[0].inst) : 64'(NOP));
        chk("commit", 64'(idu_c),   (q.size() != 0) ? 64'(q[0].c) : 64'd0);
`ifdef YSYX_23060136_IFID_PERF_EN
        chk("stall_cnt",  perf_stall,  m_stall);
        chk("bubble_cnt", perf_bubble, m_bubble);
`endif
    endtask

    task automatic step(input bit v, input logic [63:0] pc, input logic [31:0] inst, input bit c,
                        input bit rdy, input bit fl, input bit r);
        bit   push, pop;
        ent_t e;
        ifu_v = v; ifu_pc = pc; ifu_inst = inst; ifu_c = c;
        idu_rdy = rdy; flush = fl; rst = r;
        @(posedge clk);
        push = v && (q.size() < 2);
        pop  = (q.size() != 0) && rdy;
        e    = '{pc: pc, inst: inst, c: c};
`ifdef YSYX_23060136_IFID_PERF_EN
        if (r) begin
            m_stall = 0; m_bubble = 0;
        end else begin
            if (q.size() != 0 && !rdy) m_stall++;
            if (q.size() == 0) m_bubble++;
        end
`endif
        if (r) begin
            q.delete(); shown_pc = 0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            if (q.size() != 0) shown_pc = q[0].pc;
        end
        last_push = push && !r && !fl;
        #1;
        check_all();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 64'hdead_beef_dead_beef, 32'hffff_ffff, 1'b1, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] pc_r;
        shown_pc = 0;
`ifdef YSYX_23060136_IFID_PERF_EN
        m_stall = 0; m_bubble = 0;
`endif
        // Reset held two cycles
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_valid", 64'(idu_v), 0);
        chk("rst_inst",  64'(idu_inst), 64'h13);
        chk("rst_ready", 64'(ifu_rdy), 1);

`ifdef YSYX_23060136_IFID_PERF_EN
        // Two empty cycles after reset (the push cycle is still empty), then three stalls
        idle(1'b0);
        step(1, 64'h8000_0000, 32'h0000_0093, 1, 0, 0, 0);
        idle(1'b0); idle(1'b0); idle(1'b0);
        chk("perf_stall3",  perf_stall, 64'd3);
        chk("perf_bubble2", perf_bubble, 64'd2);
        step(0, 0, 0, 0, 0, 1, 0);
`endif

        // Streaming at full rate
        step(1, 64'h8000_0000, 32'h0010_0093, 1, 1, 0, 0);
        chk("stream0", idu_pc, 64'h8000_0000);
        step(1, 64'h8000_0004, 32'h0020_0093, 1, 1, 0, 0);
        chk("stream1", idu_pc, 64'h8000_0004);
        step(1, 64'h8000_0008, 32'h0030_0093, 0, 1, 0, 0);
        chk("stream2", idu_pc, 64'h8000_0008);
        chk("stream2_v", 64'(idu_v), 1);
        idle(1'b1);
        chk("stream_empty_pc", idu_pc, 64'h8000_0008);

        // Back-pressure: A, B held; C waits at fetch
        step(1, 64'h8000_0000, 32'h0000_0a13, 1, 0, 0, 0);
        step(1, 64'h8000_0004, 32'h0000_0b13, 1, 0, 0, 0);
        chk("bp_ready0", 64'(ifu_rdy), 0);
        step(1, 64'h8000_0008, 32'h0000_0c13, 1, 0, 0, 0);
        chk("bp_holdA", idu_pc, 64'h8000_0000);
        step(1, 64'h8000_0008, 32'h0000_0c13, 1, 1, 0, 0);
        chk("bp_B", idu_pc, 64'h8000_0004);
        step(1, 64'h8000_0008, 32'h0000_0c13, 1, 1, 0, 0);
        chk("bp_C", idu_pc, 64'h8000_0008);
        idle(1'b1);

        // Flush while full with a push attempt
        step(1, 64'h100, 32'h1, 1, 0, 0, 0);
        step(1, 64'h104, 32'h2, 1, 0, 0, 0);
        step(1, 64'h108, 32'h3, 1, 0, 1, 0);
        chk("flush_valid", 64'(idu_v), 0);
        chk("flush_ready", 64'(ifu_rdy), 1);
        idle(1'b1);

        // Reset while full
        step(1, 64'h200, 32'h4, 1, 0, 0, 0);
        step(1, 64'h204, 32'h5, 1, 0, 0, 0);
        step(1, 64'h208, 32'h6, 1, 0, 0, 1);
        chk("rst_full_pc",     idu_pc, 0);
        chk("rst_full_commit", 64'(idu_c), 0);

        // Random traffic; payload is re-randomized every cycle even when not accepted
        for (int i = 0; i < 3000; i++) begin
            pc_r = {$urandom, $urandom};
            step(($urandom % 4) != 0, pc_r, $urandom, 1'($urandom), ($urandom % 3) != 0,
                 ($urandom % 16) == 0, ($urandom % 128) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
